// File: rtl/serial_paralelo_if.sv
// Serial receive bus: 1-bit stream in, aligned byte out.
// master = receiver core, slave = consumer/driver side.
interface serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       frame_strobe;

  modport master (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output frame_strobe
  );

  modport slave (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  frame_strobe
  );
endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: comma-hunt alignment, lock, byte rebuild.
// Ports: clk_32f, reset (sync, high), bus (data_in -> data_out/valid/active/strobe).
module serial_paralelo #(
  parameter logic [7:0] COMMA   = 8'hBC,
  parameter int         N_COMMA = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  serial_paralelo_if.master bus
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    ACTIVE
  } state_e;

  localparam logic [3:0] NC = 4'(N_COMMA);

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       strobe_q, strobe_d;

  logic [7:0] w;
  logic       boundary;
  logic       is_comma;

  // w is the frame candidate ending on this edge
  assign w        = {sr_q[6:0], bus.data_in};
  assign boundary = (bit_cnt_q == 3'd7);
  assign is_comma = (w == COMMA);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= SEARCH;
      sr_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      strobe_q    <= strobe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = w;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    active_d    = active_q;
    strobe_d    = 1'b0;

    unique case (state_q)
      SEARCH: begin
        bit_cnt_d = bit_cnt_q;
        if (is_comma) begin
          // this edge closes a frame; next boundary is 8 edges out
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
          if (NC == 4'd1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_q + 4'd1 == NC) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d     = SEARCH;
            comma_cnt_d = 4'd0;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          data_d   = w;
          valid_d  = !is_comma;
          strobe_d = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.active       = active_q;
  assign bus.frame_strobe = strobe_q;

endmodule
